pc_sequencer: RTL and testbench

- Fetch-stage controller that drives the PC select register's three control strobes (pc_write, beq_pc_sel, jump_pc_sel) every cycle.
- Arbitrates between branch redirects from EX, jump redirects from ID, load-use stalls, instruction-memory wait states and halt requests.
- Generates the matching IF/ID and ID/EX flush and write-enable controls.
- Sits between the hazard and branch logic and the PC register. The PC register gives pc_write priority over the redirect selects, so this block never asserts more than one strobe in a cycle.

---
 rtl/pc_sequencer_pkg.sv | 53 +++++
 rtl/pc_sequencer_if.sv | 31 +++
 rtl/pc_seq_perf_counter.sv | 23 ++
 rtl/pc_sequencer.sv | 173 +++++++++++++++++
 tb/tb_pc_sequencer.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch-stage PC sequencer.
// State codes, pending-redirect encoding, counter widths and parameter limits.
package pc_sequencer_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned FLUSH_W = 3;
  localparam int unsigned BOOT_W  = 4;
  localparam int unsigned WAIT_W  = 8;
  localparam int unsigned STALL_W = 16;

  localparam logic [STATE_W-1:0] ST_BOOT     = 3'd0;
  localparam logic [STATE_W-1:0] ST_RUN      = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT_MEM = 3'd2;
  localparam logic [STATE_W-1:0] ST_FLUSH    = 3'd3;
  localparam logic [STATE_W-1:0] ST_HALT     = 3'd4;

  localparam int unsigned FLUSH_CYCLES_MIN = 1;
  localparam int unsigned FLUSH_CYCLES_MAX = 7;
  localparam int unsigned BOOT_CYCLES_MIN  = 1;
  localparam int unsigned BOOT_CYCLES_MAX  = 15;
  localparam int unsigned MEM_TIMEOUT_MIN  = 1;
  localparam int unsigned MEM_TIMEOUT_MAX  = 255;

  typedef enum logic [1:0] {
    PEND_NONE   = 2'd0,
    PEND_BRANCH = 2'd1,
    PEND_JUMP   = 2'd2
  } pend_e;

  typedef struct packed {
    logic pc_write;
    logic beq_pc_sel;
    logic jump_pc_sel;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
  } fetch_ctrl_t;

  function automatic int unsigned clamp_u(input int unsigned v, input int unsigned lo,
                                          input int unsigned hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // A branch always wins; a held branch is never displaced by a later jump.
  function automatic pend_e pend_merge(input pend_e cur, input logic br, input logic jmp);
    if (br || (cur == PEND_BRANCH)) return PEND_BRANCH;
    if (jmp || (cur == PEND_JUMP)) return PEND_JUMP;
    return PEND_NONE;
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Hazard/branch-side inputs and PC-register-side controls of the sequencer.
interface pc_sequencer_if;
  import pc_sequencer_pkg::*;

  logic               imem_ready;
  logic               branch_taken;
  logic               jump;
  logic               load_use;
  logic               halt_req;
  logic               halt_clear;
  logic               pc_write;
  logic               beq_pc_sel;
  logic               jump_pc_sel;
  logic               if_id_write;
  logic               if_id_flush;
  logic               id_ex_flush;
  logic               fetch_timeout;
  logic [STALL_W-1:0] stall_cycles;

  modport master (
    output imem_ready, branch_taken, jump, load_use, halt_req, halt_clear,
    input  pc_write, beq_pc_sel, jump_pc_sel, if_id_write, if_id_flush, id_ex_flush,
    input  fetch_timeout, stall_cycles
  );

  modport slave (
    input  imem_ready, branch_taken, jump, load_use, halt_req, halt_clear,
    output pc_write, beq_pc_sel, jump_pc_sel, if_id_write, if_id_flush, id_ex_flush,
    output fetch_timeout, stall_cycles
  );
endinterface

// File: rtl/pc_seq_perf_counter.sv
// Saturating stall-cycle counter; holds at all-ones instead of wrapping.
module pc_seq_perf_counter
  import pc_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en_i,
  output logic [STALL_W-1:0] count_o
);

  logic [STALL_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= '0;
    end else if (en_i && (count_q != {STALL_W{1'b1}})) begin
      count_q <= count_q + STALL_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage sequencer: picks at most one PC strobe per cycle and the matching
// pipeline flush/enable controls; strobes are combinational from state and inputs.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned BOOT_CYCLES  = 2,
  parameter int unsigned MEM_TIMEOUT  = 255
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);

  localparam int unsigned FLUSH_N    = clamp_u(FLUSH_CYCLES, FLUSH_CYCLES_MIN, FLUSH_CYCLES_MAX);
  localparam int unsigned BOOT_N     = clamp_u(BOOT_CYCLES, BOOT_CYCLES_MIN, BOOT_CYCLES_MAX);
  localparam int unsigned TIMEOUT_N  = clamp_u(MEM_TIMEOUT, MEM_TIMEOUT_MIN, MEM_TIMEOUT_MAX);
  localparam int unsigned WAIT_CMP_W = WAIT_W + 1;

  localparam logic [FLUSH_W-1:0]    FLUSH_RELOAD = FLUSH_W'(FLUSH_N - 1);
  localparam logic [BOOT_W-1:0]     BOOT_LAST    = BOOT_W'(BOOT_N - 1);
  localparam logic [WAIT_CMP_W-1:0] TIMEOUT_LIM  = WAIT_CMP_W'(TIMEOUT_N);

  logic [STATE_W-1:0]    state_q, state_d;
  logic [BOOT_W-1:0]     boot_q, boot_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic [FLUSH_W-1:0]    cnt_q, cnt_d;
  pend_e                 pend_q, pend_d;
  logic                  timeout_q, timeout_d;
  pend_e                 pend_m;
  logic [WAIT_CMP_W-1:0] wait_inc;
  fetch_ctrl_t           ctrl;
  logic                  stall_en;
  logic [STALL_W-1:0]    stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_BOOT;
      boot_q    <= '0;
      wait_q    <= '0;
      cnt_q     <= '0;
      pend_q    <= PEND_NONE;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      boot_q    <= boot_d;
      wait_q    <= wait_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state and strobe decode.
  always_comb begin
    ctrl      = '0;
    state_d   = state_q;
    boot_d    = boot_q;
    wait_d    = wait_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    timeout_d = timeout_q;
    pend_m    = pend_merge(pend_q, bus.branch_taken, bus.jump);
    wait_inc  = WAIT_CMP_W'(wait_q) + WAIT_CMP_W'(1);

    case (state_q)
      ST_BOOT: begin
        if (boot_q >= BOOT_LAST) begin
          boot_d  = '0;
          state_d = ST_RUN;
        end else begin
          boot_d = boot_q + BOOT_W'(1);
        end
      end

      ST_RUN: begin
        if (bus.halt_req) begin
          state_d = ST_HALT;
        end else if (bus.branch_taken) begin
          ctrl.beq_pc_sel  = 1'b1;
          ctrl.if_id_flush = 1'b1;
          ctrl.id_ex_flush = 1'b1;
          cnt_d            = FLUSH_RELOAD;
          state_d          = (FLUSH_RELOAD != '0) ? ST_FLUSH : ST_RUN;
        end else if (bus.jump) begin
          ctrl.jump_pc_sel = 1'b1;
          ctrl.if_id_flush = 1'b1;
        end else if (bus.load_use) begin
          ctrl.id_ex_flush = 1'b1;
        end else if (!bus.imem_ready) begin
          wait_d  = WAIT_W'(1);
          state_d = ST_WAIT_MEM;
        end else begin
          ctrl.pc_write    = 1'b1;
          ctrl.if_id_write = 1'b1;
        end
      end

      // Redirects seen while the fetch is outstanding are replayed on completion.
      ST_WAIT_MEM: begin
        if (bus.imem_ready) begin
          pend_d = PEND_NONE;
          wait_d = '0;
          case (pend_m)
            PEND_BRANCH: begin
              ctrl.beq_pc_sel  = 1'b1;
              ctrl.if_id_flush = 1'b1;
              ctrl.id_ex_flush = 1'b1;
              cnt_d            = FLUSH_RELOAD;
              state_d          = (FLUSH_RELOAD != '0) ? ST_FLUSH : ST_RUN;
            end
            PEND_JUMP: begin
              ctrl.jump_pc_sel = 1'b1;
              ctrl.if_id_flush = 1'b1;
              state_d          = ST_RUN;
            end
            default: begin
              ctrl.pc_write    = 1'b1;
              ctrl.if_id_write = 1'b1;
              state_d          = ST_RUN;
            end
          endcase
        end else if (wait_inc >= TIMEOUT_LIM) begin
          timeout_d = 1'b1;
          pend_d    = PEND_NONE;
          wait_d    = '0;
          state_d   = ST_HALT;
        end else begin
          pend_d = pend_m;
          wait_d = wait_inc[WAIT_W-1:0];
        end
      end

      ST_FLUSH: begin
        ctrl.pc_write    = 1'b1;
        ctrl.if_id_flush = 1'b1;
        if (cnt_q <= FLUSH_W'(1)) begin
          cnt_d   = '0;
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q - FLUSH_W'(1);
        end
      end

      ST_HALT: begin
        if (bus.halt_clear) state_d = ST_RUN;
      end

      default: state_d = ST_BOOT;
    endcase
  end

  assign stall_en = ((state_q == ST_RUN) || (state_q == ST_WAIT_MEM)) &&
                    !(ctrl.pc_write || ctrl.beq_pc_sel || ctrl.jump_pc_sel);

  pc_seq_perf_counter u_perf (
    .clk     (clk),
    .rst     (rst),
    .en_i    (stall_en),
    .count_o (stall_cnt)
  );

  // Everything reads as zero while reset is held, registered flags included.
  assign bus.pc_write      = rst & ctrl.pc_write;
  assign bus.beq_pc_sel    = rst & ctrl.beq_pc_sel;
  assign bus.jump_pc_sel   = rst & ctrl.jump_pc_sel;
  assign bus.if_id_write   = rst & ctrl.if_id_write;
  assign bus.if_id_flush   = rst & ctrl.if_id_flush;
  assign bus.id_ex_flush   = rst & ctrl.id_ex_flush;
  assign bus.fetch_timeout = rst & timeout_q;
  assign bus.stall_cycles  = rst ? stall_cnt : '0;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: default instance plus a MEM_TIMEOUT=4 instance
// sharing the same stimulus.
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  // {pc_write, beq_pc_sel, jump_pc_sel, if_id_write, if_id_flush, id_ex_flush}
  localparam logic [5:0] V_IDLE = 6'b000000;
  localparam logic [5:0] V_RUN  = 6'b100100;
  localparam logic [5:0] V_BR   = 6'b010011;
  localparam logic [5:0] V_FL   = 6'b100010;
  localparam logic [5:0] V_JMP  = 6'b001010;
  localparam logic [5:0] V_LU   = 6'b000001;

  logic clk = 1'b0;
  logic rst;
  logic imem_ready, branch_taken, jump, load_use, halt_req, halt_clear;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pc_sequencer_if bus ();
  pc_sequencer_if bus_to ();

  assign bus.imem_ready      = imem_ready;
  assign bus.branch_taken    = branch_taken;
  assign bus.jump            = jump;
  assign bus.load_use        = load_use;
  assign bus.halt_req        = halt_req;
  assign bus.halt_clear      = halt_clear;
  assign bus_to.imem_ready   = imem_ready;
  assign bus_to.branch_taken = branch_taken;
  assign bus_to.jump         = jump;
  assign bus_to.load_use     = load_use;
  assign bus_to.halt_req     = halt_req;
  assign bus_to.halt_clear   = halt_clear;

  pc_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  pc_sequencer #(.MEM_TIMEOUT(4)) dut_to (
    .clk (clk),
    .rst (rst),
    .bus (bus_to)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic ir, input logic bt, input logic j, input logic lu,
                       input logic hr, input logic hc);
    imem_ready   = ir;
    branch_taken = bt;
    jump         = j;
    load_use     = lu;
    halt_req     = hr;
    halt_clear   = hc;
    #2;
  endtask

  task automatic chk_main(input string tag, input logic [5:0] ev, input logic [15:0] es,
                          input logic ef);
    logic [5:0] v;
    logic [1:0] nstb;
    v    = {bus.pc_write, bus.beq_pc_sel, bus.jump_pc_sel,
            bus.if_id_write, bus.if_id_flush, bus.id_ex_flush};
    nstb = 2'(bus.pc_write) + 2'(bus.beq_pc_sel) + 2'(bus.jump_pc_sel);
    chk({tag, "_vec"}, 32'(v), 32'(ev));
    chk({tag, "_onehot"}, 32'(nstb <= 2'd1), 32'd1);
    chk({tag, "_stall"}, 32'(bus.stall_cycles), 32'(es));
    chk({tag, "_ftmo"}, 32'(bus.fetch_timeout), 32'(ef));
  endtask

  task automatic chk_to(input string tag, input logic [5:0] ev, input logic [15:0] es,
                        input logic ef);
    logic [5:0] v;
    v = {bus_to.pc_write, bus_to.beq_pc_sel, bus_to.jump_pc_sel,
         bus_to.if_id_write, bus_to.if_id_flush, bus_to.id_ex_flush};
    chk({tag, "_vec"}, 32'(v), 32'(ev));
    chk({tag, "_stall"}, 32'(bus_to.stall_cycles), 32'(es));
    chk({tag, "_ftmo"}, 32'(bus_to.fetch_timeout), 32'(ef));
  endtask

  initial begin
    rst = 1'b0;
    drive(1, 0, 0, 0, 0, 0);

    // Reset held, then BOOT for two cycles, then steady fetch.
    repeat (3) begin
      tick(); drive(1, 0, 0, 0, 0, 0); chk_main("reset", V_IDLE, 16'd0, 1'b0);
    end
    rst = 1'b1;
    #1; chk_main("boot1", V_IDLE, 16'd0, 1'b0);
    tick(); drive(1, 0, 0, 0, 0, 0); chk_main("boot2", V_IDLE, 16'd0, 1'b0);
    repeat (3) begin
      tick(); drive(1, 0, 0, 0, 0, 0); chk_main("run", V_RUN, 16'd0, 1'b0);
    end

    // Taken branch, one FLUSH cycle that ignores a second branch.
    tick(); drive(1, 1, 0, 0, 0, 0); chk_main("br", V_BR, 16'd0, 1'b0);
    tick(); drive(1, 1, 0, 0, 0, 0); chk_main("br_flush", V_FL, 16'd0, 1'b0);
    tick(); drive(1, 0, 0, 0, 0, 0); chk_main("br_done", V_RUN, 16'd0, 1'b0);

    // Jump beats load-use; load-use alone bubbles ID/EX.
    tick(); drive(1, 0, 1, 1, 0, 0); chk_main("jmp_lu", V_JMP, 16'd0, 1'b0);
    tick(); drive(1, 0, 0, 1, 0, 0); chk_main("lu", V_LU, 16'd0, 1'b0);
    tick(); drive(1, 0, 0, 0, 0, 0); chk_main("lu_done", V_RUN, 16'd1, 1'b0);

    // Four-cycle memory wait with jump then branch latched; branch replayed.
    tick(); drive(0, 0, 0, 0, 0, 0); chk_main("wait1", V_IDLE, 16'd1, 1'b0);
    tick(); drive(0, 0, 1, 0, 0, 0); chk_main("wait2", V_IDLE, 16'd2, 1'b0);
    tick(); drive(0, 1, 0, 0, 0, 0); chk_main("wait3", V_IDLE, 16'd3, 1'b0);
    tick(); drive(0, 0, 0, 0, 0, 0); chk_main("wait4", V_IDLE, 16'd4, 1'b0);
    tick(); drive(1, 0, 0, 0, 0, 0); chk_main("wait_br", V_BR, 16'd5, 1'b0);
    chk("to_inst_ftmo", 32'(bus_to.fetch_timeout), 32'd1);
    tick(); drive(1, 0, 0, 0, 0, 0); chk_main("wait_flush", V_FL, 16'd5, 1'b0);
    tick(); drive(1, 0, 0, 0, 0, 0); chk_main("wait_done", V_RUN, 16'd5, 1'b0);

    // Halt request from RUN, held in HALT until cleared.
    tick(); drive(1, 0, 0, 0, 1, 0); chk_main("halt_req", V_IDLE, 16'd5, 1'b0);
    tick(); drive(1, 0, 0, 0, 0, 0); chk_main("halted", V_IDLE, 16'd6, 1'b0);
    tick(); drive(1, 0, 0, 0, 0, 1); chk_main("halt_clr", V_IDLE, 16'd6, 1'b0);
    tick(); drive(1, 0, 0, 0, 0, 0); chk_main("resume", V_RUN, 16'd6, 1'b0);

    // Timeout on the MEM_TIMEOUT=4 instance after a fresh reset.
    tick(); rst = 1'b0; drive(1, 0, 0, 0, 0, 0); chk_main("rst_gate", V_IDLE, 16'd0, 1'b0);
    tick(); rst = 1'b1; drive(1, 0, 0, 0, 0, 0); chk_to("to_boot1", V_IDLE, 16'd0, 1'b0);
    tick(); drive(1, 0, 0, 0, 0, 0); chk_to("to_boot2", V_IDLE, 16'd0, 1'b0);
    tick(); drive(1, 0, 0, 0, 0, 0); chk_to("to_run", V_RUN, 16'd0, 1'b0);
    tick(); drive(0, 0, 0, 0, 0, 0); chk_to("to_miss1", V_IDLE, 16'd0, 1'b0);
    tick(); drive(0, 0, 0, 0, 0, 0); chk_to("to_miss2", V_IDLE, 16'd1, 1'b0);
    tick(); drive(0, 0, 0, 0, 0, 0); chk_to("to_miss3", V_IDLE, 16'd2, 1'b0);
    tick(); drive(0, 0, 0, 0, 0, 0); chk_to("to_miss4", V_IDLE, 16'd3, 1'b0);
    tick(); drive(0, 0, 0, 0, 0, 0); chk_to("to_halt", V_IDLE, 16'd4, 1'b1);
    tick(); drive(1, 0, 0, 0, 0, 1); chk_to("to_clr", V_IDLE, 16'd4, 1'b1);
    tick(); drive(1, 0, 0, 0, 0, 0); chk_to("to_resume", V_RUN, 16'd4, 1'b1);

    // Reset while a branch is pending: the branch must never surface.
    tick(); drive(0, 0, 0, 0, 0, 0); chk_main("rw_miss", V_IDLE, 16'd5, 1'b0);
    tick(); drive(0, 1, 0, 0, 0, 0); chk_main("rw_pend", V_IDLE, 16'd6, 1'b0);
    tick(); rst = 1'b0; drive(0, 0, 0, 0, 0, 0); chk_main("rw_rst", V_IDLE, 16'd0, 1'b0);
    tick(); rst = 1'b1; drive(1, 0, 0, 0, 0, 0); chk_main("rw_boot1", V_IDLE, 16'd0, 1'b0);
    tick(); drive(1, 0, 0, 0, 0, 0); chk_main("rw_boot2", V_IDLE, 16'd0, 1'b0);
    repeat (3) begin
      tick(); drive(1, 0, 0, 0, 0, 0); chk_main("rw_run", V_RUN, 16'd0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
